// File: rtl/adc_capture_ctrl_if.sv
// Buffer-RAM write/read ports and downstream readout stream of adc_capture_ctrl.
// master = capture controller side; slave = buffer RAM / readout consumer side.
interface adc_capture_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                  buf_we;
  logic [ADDR_WIDTH-1:0] buf_wr_addr;
  logic [DATA_WIDTH-1:0] buf_wr_data;
  logic [ADDR_WIDTH-1:0] buf_rd_addr;
  logic [DATA_WIDTH-1:0] buf_rd_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output buf_we, buf_wr_addr, buf_wr_data, buf_rd_addr,
    input  buf_rd_data,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  buf_we, buf_wr_addr, buf_wr_data, buf_rd_addr,
    output buf_rd_data,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Triggered capture into a circular ADC sample buffer, then time-ordered readout stream.
// Optional ADC_CTRL_AUTO_REARM_EN: restart PREFILL directly after the final readout handshake.
module adc_capture_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int PRETRIG    = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  arm,
  input  logic                  trigger,
  adc_capture_ctrl_if.master    bus,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         PRE_CNT   = CW'(PRETRIG);
  localparam logic [CW-1:0]         POST_CNT  = CW'(DEPTH - PRETRIG);
  localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PRE_OFS   = ADDR_WIDTH'(PRETRIG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_WAIT_TRIG,
    S_POST,
    S_READOUT
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt, cnt_inc, remaining;
  logic                  out_valid_q;
  logic                  wr_fire, hs, last_hs, trig_fire, fill_done, post_done;

  assign wr_fire   = adc_valid && (state inside {S_PREFILL, S_WAIT_TRIG, S_POST});
  assign hs        = out_valid_q && bus.out_ready;
  assign last_hs   = hs && (remaining == CW'(1));
  assign trig_fire = (state == S_WAIT_TRIG) && trigger;
  assign cnt_inc   = cnt + 1'b1;
  assign fill_done = (state == S_PREFILL) && wr_fire && (cnt_inc == PRE_CNT);
  // cnt sits at 0 through WAIT_TRIG, so a trigger-cycle write is post sample #1
  assign post_done = wr_fire && (cnt_inc == POST_CNT) && ((state == S_POST) || trig_fire);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    busy            = (state != S_IDLE);
    done            = last_hs;
    bus.buf_we      = wr_fire;
    bus.buf_wr_addr = wr_ptr;
    bus.buf_wr_data = adc_data;
    bus.buf_rd_addr = rd_ptr + ADDR_WIDTH'(hs);
    bus.out_valid   = out_valid_q;
    bus.out_data    = bus.buf_rd_data;
    bus.out_last    = out_valid_q && (remaining == CW'(1));
    case (state)
      S_IDLE:      if (arm) state_next = S_PREFILL;
      S_PREFILL:   if (fill_done) state_next = S_WAIT_TRIG;
      S_WAIT_TRIG: begin
        if (post_done)      state_next = S_READOUT;
        else if (trig_fire) state_next = S_POST;
      end
      S_POST:      if (post_done) state_next = S_READOUT;
      S_READOUT: begin
        if (last_hs) begin
`ifdef ADC_CTRL_AUTO_REARM_EN
          state_next = S_PREFILL;
`else
          state_next = S_IDLE;
`endif
        end
      end
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      remaining   <= '0;
      trig_addr   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      out_valid_q <= (state == S_READOUT) && !last_hs;
      case (state)
        S_IDLE: begin
          if (arm) begin
            wr_ptr <= '0;
            cnt    <= '0;
          end
        end
        S_PREFILL:   if (wr_fire) cnt <= fill_done ? '0 : cnt_inc;
        S_WAIT_TRIG: begin
          if (trig_fire) begin
            trig_addr <= wr_ptr;
            cnt       <= wr_fire ? CW'(1) : '0;
          end
        end
        S_POST:      if (wr_fire) cnt <= cnt_inc;
        S_READOUT: begin
          if (hs) begin
            rd_ptr    <= rd_ptr + 1'b1;
            remaining <= remaining - 1'b1;
          end
          if (last_hs) begin
            cnt <= '0;
`ifdef ADC_CTRL_AUTO_REARM_EN
            wr_ptr <= '0;
`endif
          end
        end
        default: ;
      endcase
      // oldest retained sample sits PRETRIG slots behind the trigger address
      if (post_done) begin
        rd_ptr    <= (trig_fire ? wr_ptr : trig_addr) - PRE_OFS;
        remaining <= DEPTH_CNT;
      end
    end
  end
endmodule
